// File: rtl/kb_car_if.sv
// Bus between the keyboard front end and the drivetrain controller.
// Key levels, key ticks and race_active go in; the car state comes back out.
interface kb_car_if #(
    parameter int WIDTH  = 4,
    parameter int GEAR_W = 3,
    parameter int RPM_W  = 14,
    parameter int SPD_W  = 16
);
    logic              race_active;
    logic [WIDTH-1:0]  kb_key_pressed;
    logic [WIDTH-1:0]  kb_key_pressed_tick;
    logic [GEAR_W-1:0] gear;
    logic [RPM_W-1:0]  rpm;
    logic [SPD_W-1:0]  speed;
    logic              limiter;
    logic              shifting;
    logic              update_tick;

    modport master (
        output race_active, kb_key_pressed, kb_key_pressed_tick,
        input  gear, rpm, speed, limiter, shifting, update_tick
    );

    modport slave (
        input  race_active, kb_key_pressed, kb_key_pressed_tick,
        output gear, rpm, speed, limiter, shifting, update_tick
    );
endinterface

// File: rtl/kb_car_control.sv
// Player car drivetrain: converts throttle level and shift ticks into gear, rpm,
// speed and status flags, stepping rpm once per physics update.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   NEUTRAL | gear 0; throttle revs the engine freely, up engages gear 1
//   DRIVE   | gear 1..GEARS; up/down shift, throttle scaled by gear
//   SHIFT   | after an up-shift; ticks ignored, rpm decays for SHIFT_TICKS updates
module kb_car_control #(
    parameter int WIDTH       = 4,
    parameter int GEARS       = 5,
    parameter int TICK_DIV    = 650000,
    parameter int RPM_W       = 14,
    parameter int RPM_IDLE    = 1000,
    parameter int RPM_MAX     = 8000,
    parameter int RPM_UP      = 500,
    parameter int RPM_DN      = 250,
    parameter int SHIFT_TICKS = 3,
    parameter int SPD_W       = 16,
    parameter int SPD_SHIFT   = 4
) (
    input  logic    clk,
    input  logic    reset,
    kb_car_if.slave car
);

    localparam int GEAR_W = $clog2(GEARS + 1);
    localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CNT_W  = $clog2(SHIFT_TICKS + 1);
    localparam int PROD_W = RPM_W + GEAR_W;

    typedef logic [RPM_W:0] rpm_ext_t;

    localparam rpm_ext_t IDLE_X = rpm_ext_t'(RPM_IDLE);
    localparam rpm_ext_t MAX_X  = rpm_ext_t'(RPM_MAX);
    localparam rpm_ext_t UP_X   = rpm_ext_t'(RPM_UP);
    localparam rpm_ext_t DN_X   = rpm_ext_t'(RPM_DN);

    typedef enum logic [1:0] {
        NEUTRAL = 2'd0,
        DRIVE   = 2'd1,
        SHIFT   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [GEAR_W-1:0] gear_q, gear_d;
    logic [RPM_W-1:0]  rpm_q, rpm_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DIV_W-1:0]  div_q;
    logic [SPD_W-1:0]  speed_q, speed_d;
    logic              limiter_q;
    logic              update_tick_q;

    logic              ce;
    logic              throttle;
    logic              up_ev;
    logic              dn_ev;
    rpm_ext_t          rpm_quarter;
    rpm_ext_t          drive_inc;
    logic [RPM_W-1:0]  rpm_coast;
    logic [RPM_W-1:0]  rpm_drive;
    logic [RPM_W-1:0]  rpm_decay;
    logic [RPM_W-1:0]  rpm_upshift;
    logic [RPM_W-1:0]  rpm_dnshift;
    logic [PROD_W-1:0] prod;
    logic [PROD_W-1:0] prod_sh;
    logic              unused_keys;

    // All rpm arithmetic is one bit wider than the register so overshoot can be clamped.
    function automatic logic [RPM_W-1:0] rpm_add(input logic [RPM_W-1:0] r, input rpm_ext_t inc);
        rpm_ext_t sum;
        sum = {1'b0, r} + inc;
        if (sum > MAX_X) begin
            sum = MAX_X;
        end else if (sum < IDLE_X) begin
            sum = IDLE_X;
        end
        return sum[RPM_W-1:0];
    endfunction

    function automatic logic [RPM_W-1:0] rpm_sub(input logic [RPM_W-1:0] r, input rpm_ext_t dec);
        rpm_ext_t diff;
        if ({1'b0, r} < IDLE_X + dec) begin
            diff = IDLE_X;
        end else begin
            diff = {1'b0, r} - dec;
        end
        if (diff > MAX_X) begin
            diff = MAX_X;
        end
        return diff[RPM_W-1:0];
    endfunction

    assign throttle    = car.kb_key_pressed[0];
    assign up_ev       = car.kb_key_pressed_tick[1] & ~car.kb_key_pressed_tick[2];
    assign dn_ev       = car.kb_key_pressed_tick[2] & ~car.kb_key_pressed_tick[1];
    assign unused_keys = ^{car.kb_key_pressed[WIDTH-1:1],
                           car.kb_key_pressed_tick[WIDTH-1:3],
                           car.kb_key_pressed_tick[0]};

    assign ce = (div_q == DIV_W'(TICK_DIV - 1));

    assign rpm_quarter = rpm_ext_t'({3'b000, rpm_q[RPM_W-1:2]});
    assign drive_inc   = UP_X >> (gear_q - GEAR_W'(1));
    assign rpm_coast   = throttle ? rpm_add(rpm_q, UP_X) : rpm_sub(rpm_q, DN_X);
    assign rpm_drive   = throttle ? rpm_add(rpm_q, drive_inc) : rpm_sub(rpm_q, DN_X);
    assign rpm_decay   = rpm_sub(rpm_q, DN_X);
    assign rpm_upshift = rpm_sub(rpm_q, rpm_quarter);
    assign rpm_dnshift = rpm_add(rpm_q, rpm_quarter);

    // Shift ticks act immediately; an accepted shift swallows a coincident rpm step.
    always_comb begin
        state_d = state_q;
        gear_d  = gear_q;
        rpm_d   = rpm_q;
        cnt_d   = cnt_q;
        case (state_q)
            NEUTRAL: begin
                if (up_ev && car.race_active) begin
                    state_d = DRIVE;
                    gear_d  = GEAR_W'(1);
                end else if (ce) begin
                    rpm_d = rpm_coast;
                end
            end
            DRIVE: begin
                if (!car.race_active) begin
                    state_d = NEUTRAL;
                    gear_d  = '0;
                    if (ce) rpm_d = rpm_coast;
                end else if (up_ev && (gear_q < GEAR_W'(GEARS))) begin
                    state_d = SHIFT;
                    gear_d  = gear_q + GEAR_W'(1);
                    rpm_d   = rpm_upshift;
                    cnt_d   = CNT_W'(SHIFT_TICKS);
                end else if (dn_ev && (gear_q > GEAR_W'(1))) begin
                    gear_d = gear_q - GEAR_W'(1);
                    rpm_d  = rpm_dnshift;
                end else if (dn_ev) begin
                    state_d = NEUTRAL;
                    gear_d  = '0;
                end else if (ce) begin
                    rpm_d = rpm_drive;
                end
            end
            SHIFT: begin
                if (!car.race_active) begin
                    state_d = NEUTRAL;
                    gear_d  = '0;
                    cnt_d   = '0;
                    if (ce) rpm_d = rpm_coast;
                end else if (ce) begin
                    rpm_d = rpm_decay;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_d = DRIVE;
                end
            end
            default: begin
                state_d = NEUTRAL;
                gear_d  = '0;
                cnt_d   = '0;
            end
        endcase
    end

    assign prod    = PROD_W'(rpm_q) * PROD_W'(gear_q);
    assign prod_sh = prod >> SPD_SHIFT;
    assign speed_d = SPD_W'(prod_sh);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= NEUTRAL;
            gear_q        <= '0;
            rpm_q         <= RPM_W'(RPM_IDLE);
            cnt_q         <= '0;
            div_q         <= '0;
            speed_q       <= '0;
            limiter_q     <= 1'b0;
            update_tick_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            gear_q        <= gear_d;
            rpm_q         <= rpm_d;
            cnt_q         <= cnt_d;
            div_q         <= ce ? '0 : div_q + DIV_W'(1);
            speed_q       <= speed_d;
            limiter_q     <= (rpm_d == RPM_W'(RPM_MAX));
            update_tick_q <= ce;
        end
    end

    assign car.gear        = gear_q;
    assign car.rpm         = rpm_q;
    assign car.speed       = speed_q;
    assign car.limiter     = limiter_q;
    assign car.shifting    = (state_q == SHIFT);
    assign car.update_tick = update_tick_q;

endmodule
